task_start_sequencer: RTL and testbench

Upstream request stage for interface-hosted tasks: it buffers task requests with an argument and drives the interface `Start` signal that the consuming module watches with `always @(Interf.Start)`. `Start` is a toggle, so any edge triggers one task call. The block holds exactly one call outstanding at a time and waits for a `Done` pulse from the consumer, or for a timeout, before issuing the next. It sits between request producers and the interface instance shared with the task-calling module.

---
 rtl/task_seq_pkg.sv | 13 +
 rtl/task_req_fifo.sv | 70 +++++++
 rtl/task_start_sequencer.sv | 108 ++++++++++
 tb/tb_task_start_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/task_seq_pkg.sv
// rtl/task_seq_pkg.sv - shared state encoding and default parameters for the task start sequencer
package task_seq_pkg;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    localparam int DEF_ARG_W   = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/task_req_fifo.sv
// rtl/task_req_fifo.sv - request FIFO with registered occupancy-based full/empty
module task_req_fifo #(
    parameter  int DEPTH = 4,
    parameter  int ARG_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [ARG_W-1:0] wdata,
    output logic [ARG_W-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [ARG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rptr_q];

    // Requests that hit a full or empty FIFO are dropped here, so callers may drive raw strobes.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/task_start_sequencer.sv
// rtl/task_start_sequencer.sv - issues queued task calls as Start toggles, one outstanding at a time
module task_start_sequencer
    import task_seq_pkg::*;
#(
    parameter  int ARG_W   = DEF_ARG_W,
    parameter  int DEPTH   = DEF_DEPTH,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int LVL_W   = $clog2(DEPTH + 1),
    localparam int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Req_valid,
    input  logic [ARG_W-1:0] Req_arg,
    output logic             Req_ready,
    output logic             Start,
    output logic [ARG_W-1:0] Arg,
    input  logic             Done,
    output logic             Busy,
    output logic             Err,
    output logic [LVL_W-1:0] Level
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic [ARG_W-1:0] arg_q, arg_d;
    logic             err_q, err_d;

    logic             fifo_pop;
    logic [ARG_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    task_req_fifo #(
        .DEPTH (DEPTH),
        .ARG_W (ARG_W)
    ) u_fifo (
        .clk    (Clk),
        .resetn (Rst_n),
        .push   (Req_valid),
        .pop    (fifo_pop),
        .wdata  (Req_arg),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start_d  = start_q;
        arg_d    = arg_q;
        err_d    = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    arg_d    = fifo_rdata;
                    start_d  = ~start_q;
                    cnt_d    = '0;
                    state_d  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // Done takes priority over an expiring timeout in the same cycle.
                if (Done) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            arg_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            arg_q   <= arg_d;
            err_q   <= err_d;
        end
    end

    assign Req_ready = !fifo_full;
    assign Start     = start_q;
    assign Arg       = arg_q;
    assign Busy      = (state_q == WAIT_DONE);
    assign Err       = err_q;
    assign Level     = fifo_level;

endmodule

// File: tb/tb_task_start_sequencer.sv
// tb/tb_task_start_sequencer.sv - directed self-checking bench for task_start_sequencer
module tb_task_start_sequencer;

    logic       Clk;
    logic       Rst_n;
    logic       Req_valid;
    logic [7:0] Req_arg;
    logic       Req_ready;
    logic       Start;
    logic [7:0] Arg;
    logic       Done;
    logic       Busy;
    logic       Err;
    logic [2:0] Level;

    int vectors;
    int miscompares;
    int toggles;
    logic prev_start;

    task_start_sequencer #(
        .ARG_W   (8),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Req_valid (Req_valid),
        .Req_arg   (Req_arg),
        .Req_ready (Req_ready),
        .Start     (Start),
        .Arg       (Arg),
        .Done      (Done),
        .Busy      (Busy),
        .Err       (Err),
        .Level     (Level)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        Rst_n       = 1'b0;
        Req_valid   = 1'b1;
        Req_arg     = 8'h11;
        Done        = 1'b0;

        // Reset held with a request pending: nothing may be queued or issued.
        repeat (3) tick();
        chk("rst_start", 32'(Start), 0);
        chk("rst_arg", 32'(Arg), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_err", 32'(Err), 0);
        chk("rst_level", 32'(Level), 0);
        chk("rst_ready", 32'(Req_ready), 1);
        Rst_n     = 1'b1;
        Req_valid = 1'b0;
        tick();
        chk("rel_ready", 32'(Req_ready), 1);
        chk("rel_level", 32'(Level), 0);

        // Done while idle is ignored.
        Done = 1'b1;
        tick();
        Done = 1'b0;
        tick();
        chk("idle_done_busy", 32'(Busy), 0);
        chk("idle_done_err", 32'(Err), 0);
        chk("idle_done_start", 32'(Start), 0);

        // Single request A5, completed on the third Busy cycle.
        Req_valid = 1'b1;
        Req_arg   = 8'hA5;
        tick();
        Req_valid = 1'b0;
        chk("single_level", 32'(Level), 1);
        chk("single_start_pre", 32'(Start), 0);
        tick();
        chk("single_start", 32'(Start), 1);
        chk("single_arg", 32'(Arg), 'hA5);
        chk("single_busy1", 32'(Busy), 1);
        chk("single_level0", 32'(Level), 0);
        tick();
        chk("single_busy2", 32'(Busy), 1);
        tick();
        chk("single_busy3", 32'(Busy), 1);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        chk("single_busy_fall", 32'(Busy), 0);
        chk("single_err", 32'(Err), 0);
        chk("single_start_hold", 32'(Start), 1);

        // Five back-to-back pushes with Done low; first issues at T0.
        Req_valid = 1'b1;
        Req_arg   = 8'h01;
        tick();
        Req_arg = 8'h02;
        chk("b2b_level1", 32'(Level), 1);
        tick();
        chk("b2b_start", 32'(Start), 0);
        chk("b2b_arg", 32'(Arg), 'h01);
        chk("b2b_level_pp", 32'(Level), 1);
        Req_arg = 8'h03;
        tick();
        chk("b2b_level2", 32'(Level), 2);
        Req_arg = 8'h04;
        tick();
        chk("b2b_level3", 32'(Level), 3);
        Req_arg = 8'h05;
        tick();
        chk("b2b_level4", 32'(Level), 4);
        chk("b2b_ready_low", 32'(Req_ready), 0);
        Req_arg = 8'h06;
        tick();
        chk("b2b_stall_level", 32'(Level), 4);
        chk("b2b_stall_ready", 32'(Req_ready), 0);

        // Timeout: now at T0+4, Err must appear after edge T0+16.
        repeat (11) tick();
        chk("to_err_early", 32'(Err), 0);
        chk("to_busy_early", 32'(Busy), 1);
        tick();
        chk("to_err", 32'(Err), 1);
        chk("to_busy_fall", 32'(Busy), 0);
        chk("to_start_hold", 32'(Start), 0);
        chk("to_level", 32'(Level), 4);
        tick();
        chk("to_err_pulse", 32'(Err), 0);
        chk("to_reissue_start", 32'(Start), 1);
        chk("to_reissue_arg", 32'(Arg), 'h02);
        chk("to_reissue_busy", 32'(Busy), 1);
        chk("to_reissue_level", 32'(Level), 3);
        chk("to_ready_back", 32'(Req_ready), 1);
        tick();
        Req_valid = 1'b0;
        chk("sixth_level", 32'(Level), 4);
        chk("sixth_ready", 32'(Req_ready), 0);

        // Done in the exact timeout cycle of the call issued at T1 (now T1+1).
        repeat (14) tick();
        Done = 1'b1;
        tick();
        Done = 1'b0;
        chk("race_err", 32'(Err), 0);
        chk("race_busy", 32'(Busy), 0);
        tick();
        chk("race_err_after", 32'(Err), 0);
        chk("race_start", 32'(Start), 0);
        chk("race_arg", 32'(Arg), 'h03);
        chk("race_level", 32'(Level), 3);

        // Complete and issue 04 while pushing 07, leaving 3 queued with Start high.
        Done      = 1'b1;
        Req_valid = 1'b1;
        Req_arg   = 8'h07;
        tick();
        Done      = 1'b0;
        Req_valid = 1'b0;
        chk("pre_rst_level4", 32'(Level), 4);
        tick();
        chk("pre_rst_start", 32'(Start), 1);
        chk("pre_rst_arg", 32'(Arg), 'h04);
        chk("pre_rst_level", 32'(Level), 3);

        // Reset mid-call discards the queue and returns Start to 0.
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        chk("mid_rst_level", 32'(Level), 0);
        chk("mid_rst_start", 32'(Start), 0);
        chk("mid_rst_busy", 32'(Busy), 0);
        chk("mid_rst_arg", 32'(Arg), 0);
        chk("mid_rst_ready", 32'(Req_ready), 1);
        toggles    = 0;
        prev_start = Start;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Start !== prev_start) toggles++;
            prev_start = Start;
        end
        chk("post_rst_toggles", 32'(toggles), 0);
        chk("post_rst_busy", 32'(Busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
